// File: rtl/ssp_unit.sv
// Synchronous serial port: APB-style byte bus on one side, TI-framed serial TX/RX on the other.
// Each direction is buffered by a DEPTH-entry FIFO; all state runs on PCLK.
module ssp_unit #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             PCLK,
    input  logic             CLEAR,
    input  logic             PSEL,
    input  logic             PWRITE,
    input  logic [WIDTH-1:0] PWDATA,
    output logic [WIDTH-1:0] PRDATA,
    input  logic             SSPCLKIN,
    input  logic             SSPFSSIN,
    input  logic             SSPRXD,
    output logic             SSPCLKOUT,
    output logic             SSPFSSOUT,
    output logic             SSPTXD,
    output logic             SSPOE_B,
    output logic             SSPTXINTR,
    output logic             SSPRXINTR
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StSync, StShift} tx_state_e;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // TX FIFO
    logic [WIDTH-1:0] r_tx_mem [DEPTH];
    logic [AW-1:0]    r_tx_wr;
    logic [AW-1:0]    r_tx_rd;
    logic [CW-1:0]    r_tx_cnt;
    logic             w_tx_push;
    logic             w_tx_pop;
    logic             w_tx_full;
    logic             w_tx_empty;
    logic [WIDTH-1:0] w_tx_head;

    assign w_tx_full  = (r_tx_cnt == CW'(DEPTH));
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_push  = PSEL & PWRITE & ~w_tx_full;
    assign w_tx_head  = r_tx_mem[r_tx_rd];

    always_ff @(posedge PCLK) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr] <= PWDATA;
        end
    end

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            r_tx_wr  <= '0;
            r_tx_rd  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= ptr_inc(r_tx_wr);
            if (w_tx_pop)  r_tx_rd <= ptr_inc(r_tx_rd);
            r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
        end
    end

    // TX shifter; every TX output moves only on the PCLK edge where SSPCLKOUT rises
    tx_state_e        r_state;
    tx_state_e        w_state_nxt;
    logic             r_sclk;
    logic             r_fss;
    logic             r_txd;
    logic             r_oe_b;
    logic [WIDTH-1:0] r_tx_sr;
    logic [BW-1:0]    r_bit;
    logic             r_more;
    logic             w_fss_nxt;
    logic             w_txd_nxt;
    logic             w_oe_b_nxt;
    logic [WIDTH-1:0] w_tx_sr_nxt;
    logic [BW-1:0]    w_bit_nxt;
    logic             w_more_nxt;
    logic             w_tx_tick;

    assign w_tx_tick = ~r_sclk;

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            r_state <= StIdle;
            r_sclk  <= 1'b0;
            r_fss   <= 1'b0;
            r_txd   <= 1'b0;
            r_oe_b  <= 1'b1;
            r_tx_sr <= '0;
            r_bit   <= '0;
            r_more  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sclk  <= ~r_sclk;
            r_fss   <= w_fss_nxt;
            r_txd   <= w_txd_nxt;
            r_oe_b  <= w_oe_b_nxt;
            r_tx_sr <= w_tx_sr_nxt;
            r_bit   <= w_bit_nxt;
            r_more  <= w_more_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fss_nxt   = r_fss;
        w_txd_nxt   = r_txd;
        w_oe_b_nxt  = r_oe_b;
        w_tx_sr_nxt = r_tx_sr;
        w_bit_nxt   = r_bit;
        w_more_nxt  = r_more;
        w_tx_pop    = 1'b0;
        if (w_tx_tick) begin
            unique case (r_state)
                StIdle: begin
                    w_fss_nxt  = 1'b0;
                    w_oe_b_nxt = 1'b1;
                    w_txd_nxt  = 1'b0;
                    if (!w_tx_empty) begin
                        w_tx_pop    = 1'b1;
                        w_tx_sr_nxt = w_tx_head;
                        w_fss_nxt   = 1'b1;
                        w_state_nxt = StSync;
                    end
                end
                StSync: begin
                    w_fss_nxt   = 1'b0;
                    w_oe_b_nxt  = 1'b0;
                    w_txd_nxt   = r_tx_sr[WIDTH-1];
                    w_tx_sr_nxt = {r_tx_sr[WIDTH-2:0], 1'b0};
                    w_bit_nxt   = BW'(WIDTH - 1);
                    w_more_nxt  = 1'b0;
                    w_state_nxt = StShift;
                end
                StShift: begin
                    w_fss_nxt = 1'b0;
                    if (r_bit != '0) begin
                        w_txd_nxt   = r_tx_sr[WIDTH-1];
                        w_tx_sr_nxt = {r_tx_sr[WIDTH-2:0], 1'b0};
                        w_bit_nxt   = r_bit - 1'b1;
                        // Bit 0 leaves now: fetch the next word so frames abut.
                        if (r_bit == BW'(1) && !w_tx_empty) begin
                            w_tx_pop    = 1'b1;
                            w_tx_sr_nxt = w_tx_head;
                            w_fss_nxt   = 1'b1;
                            w_more_nxt  = 1'b1;
                        end
                    end else if (r_more) begin
                        w_oe_b_nxt  = 1'b0;
                        w_txd_nxt   = r_tx_sr[WIDTH-1];
                        w_tx_sr_nxt = {r_tx_sr[WIDTH-2:0], 1'b0};
                        w_bit_nxt   = BW'(WIDTH - 1);
                        w_more_nxt  = 1'b0;
                    end else begin
                        w_oe_b_nxt  = 1'b1;
                        w_txd_nxt   = 1'b0;
                        w_state_nxt = StIdle;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    // RX deserialiser: samples on falling edges of SSPCLKIN seen through one register
    logic             r_clkin;
    logic             r_rx_armed;
    logic [BW-1:0]    r_rx_bit;
    logic [WIDTH-2:0] r_rx_sr;
    logic             w_rx_tick;
    logic             w_rx_done;
    logic [WIDTH-1:0] w_rx_word;

    assign w_rx_tick = r_clkin & ~SSPCLKIN;
    assign w_rx_word = {r_rx_sr, SSPRXD};
    assign w_rx_done = w_rx_tick & r_rx_armed & (r_rx_bit == BW'(WIDTH - 1));

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            r_clkin    <= 1'b0;
            r_rx_armed <= 1'b0;
            r_rx_bit   <= '0;
            r_rx_sr    <= '0;
        end else begin
            r_clkin <= SSPCLKIN;
            if (w_rx_tick) begin
                if (!r_rx_armed) begin
                    r_rx_armed <= SSPFSSIN;
                    r_rx_bit   <= '0;
                end else begin
                    r_rx_sr <= w_rx_word[WIDTH-2:0];
                    if (r_rx_bit == BW'(WIDTH - 1)) begin
                        r_rx_bit   <= '0;
                        r_rx_armed <= SSPFSSIN;
                    end else begin
                        r_rx_bit <= r_rx_bit + 1'b1;
                    end
                end
            end
        end
    end

    // RX FIFO and registered read port
    logic [WIDTH-1:0] r_rx_mem [DEPTH];
    logic [AW-1:0]    r_rx_wr;
    logic [AW-1:0]    r_rx_rd;
    logic [CW-1:0]    r_rx_cnt;
    logic [WIDTH-1:0] r_prdata;
    logic             w_rx_push;
    logic             w_rx_pop;
    logic             w_rx_full;
    logic             w_rx_empty;

    assign w_rx_full  = (r_rx_cnt == CW'(DEPTH));
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_push  = w_rx_done & ~w_rx_full;
    assign w_rx_pop   = PSEL & ~PWRITE & ~w_rx_empty;

    always_ff @(posedge PCLK) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr] <= w_rx_word;
        end
    end

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
            r_rx_cnt <= '0;
            r_prdata <= '0;
        end else begin
            if (w_rx_push) r_rx_wr <= ptr_inc(r_rx_wr);
            if (w_rx_pop) begin
                r_rx_rd  <= ptr_inc(r_rx_rd);
                r_prdata <= r_rx_mem[r_rx_rd];
            end
            r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
        end
    end

    assign PRDATA    = r_prdata;
    assign SSPCLKOUT = r_sclk;
    assign SSPFSSOUT = r_fss;
    assign SSPTXD    = r_txd;
    assign SSPOE_B   = r_oe_b;
    assign SSPTXINTR = w_tx_full;
    assign SSPRXINTR = w_rx_full;

endmodule

// File: tb/tb_ssp_unit.sv
// Directed bench for ssp_unit: table-driven bus and serial vectors plus loopback,
// overflow, drop, empty-read and mid-frame reset sequences.
module tb_ssp_unit;
    logic       PCLK = 1'b0;
    logic       CLEAR;
    logic       PSEL;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       SSPCLKIN;
    logic       SSPFSSIN;
    logic       SSPRXD;
    logic       SSPCLKOUT;
    logic       SSPFSSOUT;
    logic       SSPTXD;
    logic       SSPOE_B;
    logic       SSPTXINTR;
    logic       SSPRXINTR;
    logic       lb;

    assign SSPCLKIN = lb & SSPCLKOUT;
    assign SSPFSSIN = lb & SSPFSSOUT;
    assign SSPRXD   = lb & SSPTXD;

    always #5 PCLK = ~PCLK;

    ssp_unit #(.DEPTH(4), .WIDTH(8)) dut (
        .PCLK      (PCLK),
        .CLEAR     (CLEAR),
        .PSEL      (PSEL),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .SSPCLKIN  (SSPCLKIN),
        .SSPFSSIN  (SSPFSSIN),
        .SSPRXD    (SSPRXD),
        .SSPCLKOUT (SSPCLKOUT),
        .SSPFSSOUT (SSPFSSOUT),
        .SSPTXD    (SSPTXD),
        .SSPOE_B   (SSPOE_B),
        .SSPTXINTR (SSPTXINTR),
        .SSPRXINTR (SSPRXINTR)
    );

    typedef struct packed {
        logic       psel;
        logic       pwrite;
        logic [7:0] pwdata;
        logic [7:0] exp_prdata;
        logic       exp_txintr;
        logic       exp_rxintr;
    } bus_vec_t;

    typedef struct packed {
        logic fss;
        logic oe_b;
        logic txd;
    } ser_vec_t;

    bus_vec_t bus_tab[24];
    ser_vec_t ser_tab[29];
    int       n_assert = 0;
    int       n_fail   = 0;

    function automatic bus_vec_t bw(input logic [7:0] d, input logic [7:0] pr, input logic tx);
        bw = '{psel: 1'b1, pwrite: 1'b1, pwdata: d, exp_prdata: pr, exp_txintr: tx,
               exp_rxintr: 1'b0};
    endfunction

    function automatic bus_vec_t br(input logic [7:0] pr, input logic rx);
        br = '{psel: 1'b1, pwrite: 1'b0, pwdata: 8'h00, exp_prdata: pr, exp_txintr: 1'b0,
               exp_rxintr: rx};
    endfunction

    function automatic ser_vec_t sv(input logic f, input logic o, input logic t);
        sv = '{fss: f, oe_b: o, txd: t};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_high();
        @(negedge PCLK);
        if (!SSPCLKOUT) @(negedge PCLK);
    endtask

    task automatic wait_fss(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (SSPCLKOUT && SSPFSSOUT) found = 1'b1;
            else @(negedge PCLK);
        end
        check(name, 8'(found), 8'd1);
    endtask

    task automatic run_bus(input int first, input int last, input string tag);
        for (int i = first; i <= last; i++) begin
            PSEL   = bus_tab[i].psel;
            PWRITE = bus_tab[i].pwrite;
            PWDATA = bus_tab[i].pwdata;
            @(negedge PCLK);
            check($sformatf("%s[%0d].prdata", tag, i), PRDATA, bus_tab[i].exp_prdata);
            check($sformatf("%s[%0d].txintr", tag, i), 8'(SSPTXINTR), 8'(bus_tab[i].exp_txintr));
            check($sformatf("%s[%0d].rxintr", tag, i), 8'(SSPRXINTR), 8'(bus_tab[i].exp_rxintr));
        end
        PSEL = 1'b0;
    endtask

    task automatic run_ser(input int first, input int last, input string tag);
        for (int i = first; i <= last; i++) begin
            if (i != first) next_high();
            check($sformatf("%s[%0d].fss_oeb_txd", tag, i - first),
                  8'({SSPFSSOUT, SSPOE_B, SSPTXD}),
                  8'({ser_tab[i].fss, ser_tab[i].oe_b, ser_tab[i].txd}));
        end
    endtask

    task automatic read_once();
        PSEL   = 1'b1;
        PWRITE = 1'b0;
        @(negedge PCLK);
        PSEL   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet;

        // Overflow in loopback: 0x94 to shifter, 4 held, 3 dropped
        bus_tab[0]  = bw(8'h94, 8'h00, 1'b0);
        bus_tab[1]  = bw(8'h0F, 8'h00, 1'b0);
        bus_tab[2]  = bw(8'h51, 8'h00, 1'b0);
        bus_tab[3]  = bw(8'h24, 8'h00, 1'b0);
        bus_tab[4]  = bw(8'h67, 8'h00, 1'b1);
        bus_tab[5]  = bw(8'hF3, 8'h00, 1'b1);
        bus_tab[6]  = bw(8'hB6, 8'h00, 1'b1);
        bus_tab[7]  = bw(8'h84, 8'h00, 1'b1);
        bus_tab[8]  = br(8'h94, 1'b0);
        bus_tab[9]  = br(8'h0F, 1'b0);
        bus_tab[10] = br(8'h51, 1'b0);
        bus_tab[11] = br(8'h24, 1'b0);
        bus_tab[12] = br(8'h67, 1'b0);
        bus_tab[13] = br(8'h67, 1'b0);
        // Five words, no reads until drained: fifth arrival is dropped
        bus_tab[14] = bw(8'h11, 8'h67, 1'b0);
        bus_tab[15] = bw(8'h22, 8'h67, 1'b0);
        bus_tab[16] = bw(8'h33, 8'h67, 1'b0);
        bus_tab[17] = bw(8'h44, 8'h67, 1'b0);
        bus_tab[18] = bw(8'h55, 8'h67, 1'b1);
        bus_tab[19] = br(8'h11, 1'b0);
        bus_tab[20] = br(8'h22, 1'b0);
        bus_tab[21] = br(8'h33, 1'b0);
        bus_tab[22] = br(8'h44, 1'b0);
        bus_tab[23] = br(8'h44, 1'b0);

        // Single 0x35 frame, one entry per SSPCLKOUT high phase
        ser_tab[0]  = sv(1'b1, 1'b1, 1'b0);
        ser_tab[1]  = sv(1'b0, 1'b0, 1'b0);
        ser_tab[2]  = sv(1'b0, 1'b0, 1'b0);
        ser_tab[3]  = sv(1'b0, 1'b0, 1'b1);
        ser_tab[4]  = sv(1'b0, 1'b0, 1'b1);
        ser_tab[5]  = sv(1'b0, 1'b0, 1'b0);
        ser_tab[6]  = sv(1'b0, 1'b0, 1'b1);
        ser_tab[7]  = sv(1'b0, 1'b0, 1'b0);
        ser_tab[8]  = sv(1'b0, 1'b0, 1'b1);
        ser_tab[9]  = sv(1'b0, 1'b1, 1'b0);
        ser_tab[10] = sv(1'b0, 1'b1, 1'b0);
        // Back-to-back 0x35 then 0xAE, frame sync rides on bit0 of 0x35
        ser_tab[11] = sv(1'b1, 1'b1, 1'b0);
        ser_tab[12] = sv(1'b0, 1'b0, 1'b0);
        ser_tab[13] = sv(1'b0, 1'b0, 1'b0);
        ser_tab[14] = sv(1'b0, 1'b0, 1'b1);
        ser_tab[15] = sv(1'b0, 1'b0, 1'b1);
        ser_tab[16] = sv(1'b0, 1'b0, 1'b0);
        ser_tab[17] = sv(1'b0, 1'b0, 1'b1);
        ser_tab[18] = sv(1'b0, 1'b0, 1'b0);
        ser_tab[19] = sv(1'b1, 1'b0, 1'b1);
        ser_tab[20] = sv(1'b0, 1'b0, 1'b1);
        ser_tab[21] = sv(1'b0, 1'b0, 1'b0);
        ser_tab[22] = sv(1'b0, 1'b0, 1'b1);
        ser_tab[23] = sv(1'b0, 1'b0, 1'b0);
        ser_tab[24] = sv(1'b0, 1'b0, 1'b1);
        ser_tab[25] = sv(1'b0, 1'b0, 1'b1);
        ser_tab[26] = sv(1'b0, 1'b0, 1'b1);
        ser_tab[27] = sv(1'b0, 1'b0, 1'b0);
        ser_tab[28] = sv(1'b0, 1'b1, 1'b0);

        // Reset with a write pending on the bus
        lb     = 1'b0;
        CLEAR  = 1'b1;
        PSEL   = 1'b1;
        PWRITE = 1'b1;
        PWDATA = 8'hFF;
        repeat (3) @(negedge PCLK);
        check("reset.clk_fss_txd_oeb", 8'({SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B}), 8'h01);
        check("reset.prdata", PRDATA, 8'h00);
        check("reset.intr", 8'({SSPTXINTR, SSPRXINTR}), 8'h00);
        CLEAR = 1'b0;
        PSEL  = 1'b0;
        quiet = 1'b1;
        repeat (30) begin
            @(negedge PCLK);
            if (SSPFSSOUT || !SSPOE_B) quiet = 1'b0;
        end
        check("reset.nothing_queued", 8'(quiet), 8'd1);

        // Single word, serial inputs held low
        PSEL   = 1'b1;
        PWRITE = 1'b1;
        PWDATA = 8'h35;
        @(negedge PCLK);
        PSEL = 1'b0;
        wait_fss("single.fss_seen");
        run_ser(0, 10, "single");
        check("single.rxintr", 8'(SSPRXINTR), 8'd0);
        read_once();
        check("single.empty_read", PRDATA, 8'h00);

        // Back-to-back frames
        PSEL   = 1'b1;
        PWRITE = 1'b1;
        PWDATA = 8'h35;
        @(negedge PCLK);
        PWDATA = 8'hAE;
        @(negedge PCLK);
        PSEL = 1'b0;
        wait_fss("b2b.fss_seen");
        run_ser(11, 28, "b2b");

        // Overflow with loopback, then receive with one early read
        lb = 1'b1;
        @(negedge PCLK);
        run_bus(0, 7, "ovf");
        for (int i = 0; i < 300 && !SSPRXINTR; i++) @(negedge PCLK);
        check("ovf.rx_full_seen", 8'(SSPRXINTR), 8'd1);
        run_bus(8, 8, "ovf_rd");
        repeat (40) @(negedge PCLK);
        check("ovf.rx_full_again", 8'(SSPRXINTR), 8'd1);
        run_bus(9, 13, "rd");
        repeat (60) @(negedge PCLK);
        check("ovf.tx_drained", 8'(SSPOE_B), 8'd1);
        run_bus(13, 13, "rd_late");

        // RX overflow drop, then empty read
        run_bus(14, 18, "drop_wr");
        repeat (150) @(negedge PCLK);
        check("drop.rx_full", 8'(SSPRXINTR), 8'd1);
        run_bus(19, 23, "drop_rd");

        // Reset mid-frame with a second word still queued
        PSEL   = 1'b1;
        PWRITE = 1'b1;
        PWDATA = 8'hC3;
        @(negedge PCLK);
        PWDATA = 8'h3C;
        @(negedge PCLK);
        PSEL = 1'b0;
        wait_fss("abort.fss_seen");
        repeat (3) next_high();
        check("abort.mid_frame_oeb", 8'(SSPOE_B), 8'd0);
        CLEAR = 1'b1;
        #1;
        check("abort.async_outputs", 8'({SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B}), 8'h01);
        check("abort.async_prdata", PRDATA, 8'h00);
        @(negedge PCLK);
        CLEAR = 1'b0;
        quiet = 1'b1;
        repeat (60) begin
            @(negedge PCLK);
            if (SSPFSSOUT || !SSPOE_B) quiet = 1'b0;
        end
        check("abort.tx_fifo_cleared", 8'(quiet), 8'd1);
        check("abort.rxintr", 8'(SSPRXINTR), 8'd0);
        read_once();
        check("abort.no_partial_word", PRDATA, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
